// File: rtl/sd_pattern_param_if.sv
// Serial pattern detector bus.
// Carries the qualified serial input (en, clr, PI) and the detector results
// (PO, po_q, match_cnt).
//   master : drives en/clr/PI and observes the results (the stream source)
//   slave  : the detector itself
interface sd_pattern_param_if #(
   parameter int unsigned CNT_W = 8
) ();
   logic             en;
   logic             clr;
   logic             PI;
   logic             PO;
   logic             po_q;
   logic [CNT_W-1:0] match_cnt;

   modport master (
      output en, clr, PI,
      input  PO, po_q, match_cnt
   );

   modport slave (
      input  en, clr, PI,
      output PO, po_q, match_cnt
   );
endinterface

// File: rtl/sd_pattern_param.sv
// Parametrised serial sequence detector (Mealy, MSB first).
// Detects PATTERN (N bits, PATTERN[N-1] received first) on a qualified 1-bit stream.
// Overlapping or non-overlapping detection is selected by OVERLAP. A match is reported
// combinationally on PO, registered one cycle later on po_q, and counted in a saturating
// counter.
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous active-low reset
//   bus.en         PI is valid this cycle
//   bus.clr        synchronous clear of detector state and counter (priority over en)
//   bus.PI         serial data bit
//   bus.PO         combinational match, high while the last pattern bit is on PI
//   bus.po_q       PO delayed by one cycle
//   bus.match_cnt  saturating match count since reset/clr
module sd_pattern_param #(
   parameter int unsigned  N       = 4,
   parameter logic [N-1:0] PATTERN = 4'b1011,
   parameter bit           OVERLAP = 1'b0,
   parameter int unsigned  CNT_W   = 8
) (
   input logic              clk,
   input logic              reset,
   sd_pattern_param_if.slave bus
);
   localparam int          NN = N;
   localparam int unsigned SW = $clog2(N);
   localparam int unsigned NS = 2 ** SW;
   localparam int unsigned TW = NS * 2 * SW;

   // KMP next state from prefix length s on input bit b. Encodings s >= N are unused and
   // fall back to 0 so a corrupted state recovers on the next enabled bit.
   function automatic int kmp_next(int s, logic b);
      logic [N-1:0] str;
      logic         ok;
      int           kmax;
      if (s >= NN) return 0;
      if (!OVERLAP && (s == NN - 1) && (b == PATTERN[0])) return 0;
      str = '0;
      for (int i = 0; i < s; i++) str[i] = PATTERN[NN-1-i];
      str[s] = b;
      // A full match (length N) must fall back to a proper border, hence the N-1 cap.
      kmax = (s + 1 < NN) ? s + 1 : NN - 1;
      for (int k = kmax; k > 0; k--) begin
         ok = 1'b1;
         for (int j = 0; j < k; j++) begin
            if (str[s+1-k+j] != PATTERN[NN-1-j]) ok = 1'b0;
         end
         if (ok) return k;
      end
      return 0;
   endfunction

   // Table packed as entries of SW bits, indexed by {state, input bit}.
   function automatic logic [TW-1:0] build_tbl();
      logic [TW-1:0] t;
      t = '0;
      for (int s = 0; s < int'(NS); s++) begin
         for (int b = 0; b < 2; b++) begin
            t[(s*2+b)*SW +: SW] = SW'(kmp_next(s, b[0]));
         end
      end
      return t;
   endfunction

   localparam logic [TW-1:0] NextTbl = build_tbl();

   logic [SW-1:0]    s_q, s_d;
   logic [SW:0]      tbl_idx;
   int unsigned      tbl_base;
   logic             match;
   logic             po_dly_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      match = reset & bus.en & ~bus.clr & (s_q == SW'(NN - 1)) & (bus.PI == PATTERN[0]);
   end

   always_comb begin
      tbl_idx  = {s_q, bus.PI};
      tbl_base = 32'(tbl_idx) * SW;
      s_d      = s_q;
      if (bus.clr) begin
         s_d = '0;
      end else if (bus.en) begin
         s_d = NextTbl[tbl_base +: SW];
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (bus.clr) begin
         cnt_d = '0;
      end else if (match && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s_q      <= '0;
         po_dly_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         s_q      <= s_d;
         po_dly_q <= match;
         cnt_q    <= cnt_d;
      end
   end

   assign bus.PO        = match;
   assign bus.po_q      = po_dly_q;
   assign bus.match_cnt = cnt_q;
endmodule
